// File: rtl/data_sram_responder_if.sv
// Data-SRAM request/response bundle between the EXE/MEM stages (master)
// and the responding memory (slave).
interface data_sram_responder_if;
  logic        data_sram_req;
  logic        data_sram_wr;
  logic [1:0]  data_sram_size;
  logic [3:0]  data_sram_wstrb;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic        data_sram_addr_ok;
  logic        data_sram_data_ok;
  logic [31:0] data_sram_rdata;

  modport master (
    output data_sram_req, data_sram_wr, data_sram_size, data_sram_wstrb,
           data_sram_addr, data_sram_wdata,
    input  data_sram_addr_ok, data_sram_data_ok, data_sram_rdata
  );

  modport slave (
    input  data_sram_req, data_sram_wr, data_sram_size, data_sram_wstrb,
           data_sram_addr, data_sram_wdata,
    output data_sram_addr_ok, data_sram_data_ok, data_sram_rdata
  );
endinterface

// File: rtl/data_sram_responder.sv
// Word-addressed data memory answering in-order requests after a fixed latency,
// with a small outstanding-request FIFO and optional LFSR-driven addr_ok stalls.
module data_sram_responder #(
  parameter int ADDR_W     = 12,
  parameter int LAT        = 2,
  parameter int DEPTH      = 2,
  parameter bit RAND_STALL = 1'b0
) (
  input  logic                clk,
  input  logic                reset,
  data_sram_responder_if.slave bus
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CD_W  = (LAT > 1) ? $clog2(LAT) : 1;
  localparam logic [CD_W-1:0] CD_INIT = CD_W'(LAT - 1);

  logic [31:0]       mem [2**ADDR_W];
  logic [CD_W-1:0]   cd [DEPTH];
  logic              ent_wr [DEPTH];
  logic [31:0]       ent_data [DEPTH];
  logic [DEPTH-1:0]  valid;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              reset_q;
  logic [15:0]       lfsr;
  logic              lfsr_fb;
  logic              stall_ok;
  logic              addr_ok;
  logic              accept;
  logic              retire;
  logic [ADDR_W-1:0] idx;
  logic              unused_bits;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // size is informational and the upper address bits alias onto the array
  assign unused_bits = ^{bus.data_sram_size, bus.data_sram_addr[31:ADDR_W+2],
                         bus.data_sram_addr[1:0]};

  assign idx      = bus.data_sram_addr[ADDR_W+1:2];
  assign lfsr_fb  = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];
  assign stall_ok = RAND_STALL ? lfsr[0] : 1'b1;
  // No retire bypass: a full FIFO refuses even when the head leaves this cycle
  assign addr_ok  = ~reset & ~reset_q & (count < CNT_W'(DEPTH)) & stall_ok;
  assign accept   = bus.data_sram_req & addr_ok;
  assign retire   = ~reset & valid[rd_ptr] & (cd[rd_ptr] == '0);

  assign bus.data_sram_addr_ok = addr_ok;
  assign bus.data_sram_data_ok = retire;
  assign bus.data_sram_rdata   = (retire & ~ent_wr[rd_ptr]) ? ent_data[rd_ptr] : 32'h0;

  always_ff @(posedge clk) begin
    if (reset) begin
      valid   <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      reset_q <= 1'b1;
      lfsr    <= 16'hACE1;
      for (int i = 0; i < DEPTH; i++) cd[i] <= '0;
    end else begin
      reset_q <= 1'b0;
      lfsr    <= {lfsr_fb, lfsr[15:1]};
      for (int i = 0; i < DEPTH; i++) begin
        if (valid[i] && cd[i] != '0) cd[i] <= cd[i] - 1'b1;
      end
      if (retire) begin
        valid[rd_ptr] <= 1'b0;
        rd_ptr        <= ptr_inc(rd_ptr);
      end
      if (accept) begin
        valid[wr_ptr] <= 1'b1;
        cd[wr_ptr]    <= CD_INIT;
        wr_ptr        <= ptr_inc(wr_ptr);
      end
      unique case ({accept, retire})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Read data is captured at acceptance, so later writes cannot alter it
  always_ff @(posedge clk) begin
    if (accept) begin
      ent_wr[wr_ptr]   <= bus.data_sram_wr;
      ent_data[wr_ptr] <= bus.data_sram_wr ? 32'h0 : mem[idx];
    end
  end

  always_ff @(posedge clk) begin
    if (accept && bus.data_sram_wr) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.data_sram_wstrb[b]) mem[idx][8*b +: 8] <= bus.data_sram_wdata[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_sram_responder.sv
// Scoreboard bench: five responder instances with different LAT/RAND_STALL
// settings, exercised one after another through a shared in-order queue.
module tb_data_sram_responder;

  typedef struct {
    int          inst;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  logic        req   [5];
  logic        wr    [5];
  logic [1:0]  size  [5];
  logic [3:0]  wstrb [5];
  logic [31:0] addr  [5];
  logic [31:0] wdata [5];
  logic [4:0]  addr_ok;
  logic [4:0]  data_ok;
  logic [31:0] rdata [5];

  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [31:0] model [int];

  function automatic int lat_of(input int i);
    return (i == 1) ? 4 : (i == 2) ? 1 : (i == 3) ? 3 : 2;
  endfunction

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 5; g++) begin : g_dut
    data_sram_responder_if bus ();
    assign bus.data_sram_req   = req[g];
    assign bus.data_sram_wr    = wr[g];
    assign bus.data_sram_size  = size[g];
    assign bus.data_sram_wstrb = wstrb[g];
    assign bus.data_sram_addr  = addr[g];
    assign bus.data_sram_wdata = wdata[g];
    assign addr_ok[g] = bus.data_sram_addr_ok;
    assign data_ok[g] = bus.data_sram_data_ok;
    assign rdata[g]   = bus.data_sram_rdata;

    data_sram_responder #(
      .ADDR_W    (12),
      .LAT       (lat_of(g)),
      .DEPTH     (2),
      .RAND_STALL(g == 4)
    ) u_dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
    );
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Response monitor: every data_ok must match the oldest outstanding expectation
  always @(negedge clk) begin
    for (int i = 0; i < 5; i++) begin
      if (data_ok[i] === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("dok_spurious_inst", 32'(i), 32'hFFFF_FFFF);
        end else begin
          mon_e = exp_q.pop_front();
          check("dok_inst", 32'(i), 32'(mon_e.inst));
          check("dok_rdata", rdata[i], mon_e.data);
          check("dok_cycle", 32'(cyc), 32'(mon_e.cyc));
        end
      end
    end
  end

  task automatic issue(input int inst, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] s, output int acc);
    int          n;
    int          key;
    logic [31:0] e;
    exp_t        x;
    @(negedge clk);
    req[inst]   = 1'b1;
    wr[inst]    = w;
    addr[inst]  = a;
    wdata[inst] = d;
    wstrb[inst] = s;
    size[inst]  = 2'd2;
    n = 0;
    while (addr_ok[inst] !== 1'b1 && n < 64) begin
      @(negedge clk);
      n++;
    end
    acc = -1;
    if (addr_ok[inst] !== 1'b1) begin
      check("addr_ok_wait", {31'b0, addr_ok[inst]}, 32'h1);
      req[inst] = 1'b0;
    end else begin
      key = inst * 8192 + int'(a[13:2]);
      x.inst = inst;
      x.cyc  = cyc + lat_of(inst);
      if (w) begin
        e = model.exists(key) ? model[key] : 32'h0;
        for (int b = 0; b < 4; b++) if (s[b]) e[8*b +: 8] = d[8*b +: 8];
        model[key] = e;
        x.data = 32'h0;
      end else begin
        x.data = model[key];
      end
      exp_q.push_back(x);
      acc = cyc + 1;
      @(posedge clk);
    end
  endtask

  task automatic idle(input int inst);
    @(negedge clk);
    req[inst] = 1'b0;
  endtask

  task automatic drain(input int max_cyc);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    check("drain_empty", 32'(exp_q.size()), 32'h0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

  initial begin
    int acc [8];
    int dummy;
    for (int i = 0; i < 5; i++) begin
      req[i] = 1'b0; wr[i] = 1'b0; size[i] = 2'd0; wstrb[i] = 4'h0;
      addr[i] = 32'h0; wdata[i] = 32'h0;
    end
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_addr_ok", {31'b0, addr_ok[0]}, 32'h0);
    check("rst_data_ok", {31'b0, data_ok[0]}, 32'h0);
    check("rst_rdata", rdata[0], 32'h0);
    check("rst_addr_ok_rand", {31'b0, addr_ok[4]}, 32'h0);
    reset = 1'b0;
    #1;
    check("post_rst_addr_ok", {31'b0, addr_ok[0]}, 32'h0);
    @(negedge clk);
    check("ready_addr_ok", {31'b0, addr_ok[0]}, 32'h1);

    // LAT=2: write then read-after-write, byte lane write, wstrb=0 no-op
    issue(0, 1'b1, 32'h10, 32'h1122_3344, 4'hF, acc[0]);
    issue(0, 1'b0, 32'h10, 32'h0, 4'h0, acc[1]);
    check("lat2_b2b_accept", 32'(acc[1] - acc[0]), 32'h1);
    issue(0, 1'b1, 32'h13, 32'hAA00_0000, 4'h8, dummy);
    issue(0, 1'b0, 32'h10, 32'h0, 4'h0, dummy);
    issue(0, 1'b1, 32'h10, 32'hFFFF_FFFF, 4'h0, dummy);
    issue(0, 1'b0, 32'h10, 32'h0, 4'h0, dummy);
    issue(0, 1'b0, 32'h1_0010, 32'h0, 4'h0, dummy);
    idle(0);
    drain(20);

    // LAT=4, DEPTH=2: two accepts, then refusal until the head pops
    for (int i = 0; i < 4; i++) issue(1, 1'b1, 32'(4 * i), 32'hB000_0000 + 32'(i), 4'hF, dummy);
    idle(1);
    drain(40);
    for (int i = 0; i < 4; i++) issue(1, 1'b0, 32'(4 * i), 32'h0, 4'h0, acc[i]);
    idle(1);
    check("lat4_acc1", 32'(acc[1] - acc[0]), 32'd1);
    check("lat4_acc2", 32'(acc[2] - acc[0]), 32'd5);
    check("lat4_acc3", 32'(acc[3] - acc[0]), 32'd6);
    drain(40);

    // LAT=1: eight back-to-back reads, one per cycle
    for (int i = 0; i < 8; i++) issue(2, 1'b1, 32'(4 * i), 32'(i), 4'hF, dummy);
    idle(2);
    drain(20);
    for (int i = 0; i < 8; i++) issue(2, 1'b0, 32'(4 * i), 32'h0, 4'h0, acc[i]);
    idle(2);
    for (int i = 1; i < 8; i++) check("lat1_b2b_accept", 32'(acc[i] - acc[0]), 32'(i));
    drain(20);

    // LAT=3: reset one cycle after a read accept drops the response
    issue(3, 1'b1, 32'h40, 32'hCAFE_F00D, 4'hF, dummy);
    idle(3);
    drain(20);
    issue(3, 1'b0, 32'h40, 32'h0, 4'h0, dummy);
    @(negedge clk);
    reset  = 1'b1;
    req[3] = 1'b0;
    exp_q.delete();
    #1;
    check("midrst_addr_ok", {31'b0, addr_ok[3]}, 32'h0);
    @(negedge clk);
    check("midrst_addr_ok_hold", {31'b0, addr_ok[3]}, 32'h0);
    check("midrst_data_ok", {31'b0, data_ok[3]}, 32'h0);
    check("midrst_rdata", rdata[3], 32'h0);
    reset = 1'b0;
    #1;
    check("midrst_after_addr_ok", {31'b0, addr_ok[3]}, 32'h0);
    repeat (5) @(negedge clk);
    check("midrst_resume_addr_ok", {31'b0, addr_ok[3]}, 32'h1);
    issue(3, 1'b0, 32'h40, 32'h0, 4'h0, dummy);
    idle(3);
    drain(20);

    // RAND_STALL: random traffic over eight preloaded words
    for (int i = 0; i < 8; i++) issue(4, 1'b1, 32'h100 + 32'(4 * i), $urandom, 4'hF, dummy);
    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 3) == 0) idle(4);
      issue(4, 1'($urandom_range(0, 1)),
            32'h100 + 32'(4 * $urandom_range(0, 7)) + 32'($urandom_range(0, 3)),
            $urandom, 4'($urandom_range(0, 15)), dummy);
    end
    idle(4);
    drain(200);

    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
